// File: rtl/med_pkg.sv
// Shared constants and FSM state type for the median sequencer slice.
package med_pkg;

  localparam int NBR         = 9;
  localparam int ROUNDS      = 4;
  localparam int PASS        = 8;
  localparam int SORT_CYCLES = ROUNDS * (PASS + 1) + PASS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SORT = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/med_seq_if.sv
// Valid/ready pixel stream; used for both the pixel input and the result output.
interface med_seq_if #(
  parameter int SIZE = 8
) ();

  logic [SIZE-1:0] data;
  logic            valid;
  logic            ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);

endinterface

// File: rtl/med_buf.sv
// 9-entry in-order pixel buffer: write pointer, read pointer and fill count.
module med_buf #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 9,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            wr,
  input  logic [SIZE-1:0] wdata,
  input  logic            rd,
  output logic [SIZE-1:0] rdata,
  output logic [CW-1:0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic            wr_ok, rd_ok;

  // Writes into a full buffer and reads from an empty one are dropped so
  // the count can never leave 0..DEPTH.
  assign wr_ok = wr && (count != CW'(DEPTH));
  assign rd_ok = rd && (count != '0);
  assign rdata = mem[rp];

  // Storage needs no reset: an empty count makes its contents invisible.
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wp] <= wdata;
  end

  // Pointer and count bookkeeping, cleared by reset to discard the window.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
      if (rd_ok) rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + 1'b1;
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

endmodule

// File: rtl/med_eng.sv
// Median engine: 9-register ring with one compare/swap between R7 and R8.
// BYP=0 bubbles the running maximum into R8; BYP=1 shifts R7 into R8,
// dropping the old R8, and injects zero at R0 so the dropped maximum is
// replaced by a value that can never win again. DSI=1 loads DI at R0.
module med_eng #(
  parameter int SIZE = 8
) (
  input  logic            CLK,
  input  logic            DSI,
  input  logic            BYP,
  input  logic [SIZE-1:0] DI,
  output logic [SIZE-1:0] DO
);

  logic [SIZE-1:0] r [9];
  logic [SIZE-1:0] hi, lo;

  assign hi = (r[7] > r[8]) ? r[7] : r[8];
  assign lo = (r[7] > r[8]) ? r[8] : r[7];
  assign DO = r[8];

  // Ring shift with the compare/swap at the tail.
  always_ff @(posedge CLK) begin
    r[0] <= DSI ? DI : (BYP ? '0 : lo);
    for (int i = 1; i < 8; i++) r[i] <= r[i-1];
    r[8] <= BYP ? r[7] : hi;
  end

endmodule

// File: rtl/med_seq.sv
// Median window sequencer: collects 9 pixels, drives the engine schedule
// (9 load cycles, 44 sort cycles), captures the median and hands it out.
module med_seq #(
  parameter int SIZE = 8,
  parameter int NBR  = 9
) (
  input  logic            CLK,
  input  logic            nRST,
  med_seq_if.slave        pix,
  med_seq_if.master       res,
  output logic            DSI,
  output logic            BYP,
  output logic [SIZE-1:0] DI,
  input  logic [SIZE-1:0] DO
);

  import med_pkg::*;

  localparam int          CW         = $clog2(NBR + 1);
  localparam logic [3:0]  LAST_STEP  = 4'(PASS);
  localparam logic [2:0]  LAST_ROUND = 3'(ROUNDS);

  state_t          state;
  logic            run;
  logic [3:0]      step;
  logic [2:0]      round;
  logic            cap;
  logic [CW-1:0]   cnt;
  logic [SIZE-1:0] rdata;
  logic            accept, full_nxt, hs, sort_done;

  // run holds PIX_READY low until the first edge with reset released.
  assign pix.ready = run && (cnt < CW'(NBR)) && (state != LOAD);
  assign accept    = pix.valid && pix.ready;
  // Full now, or the 9th pixel lands this cycle.
  assign full_nxt  = (cnt == CW'(NBR)) || ((cnt == CW'(NBR - 1)) && accept);
  assign hs        = res.valid && res.ready;
  // The final pass has no drop cycle: it ends at step PASS-1 of round ROUNDS.
  assign sort_done = (state == SORT) && (round == LAST_ROUND) &&
                     (step == LAST_STEP - 4'd1);

  assign DSI = (state == LOAD);
  assign BYP = (state == LOAD) || ((state == SORT) && (step == LAST_STEP));
  assign DI  = (state == LOAD) ? rdata : '0;

  med_buf #(.SIZE(SIZE), .DEPTH(NBR), .CW(CW)) u_buf (
    .CLK   (CLK),
    .nRST  (nRST),
    .wr    (accept),
    .wdata (pix.data),
    .rd    (state == LOAD),
    .rdata (rdata),
    .count (cnt)
  );

  // Window FSM with load/sort step and round counters. The engine's last
  // register only settles at the edge closing the final sort cycle, so the
  // capture happens one cycle later inside OUT (cap flag).
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      run       <= 1'b0;
      step      <= '0;
      round     <= '0;
      cap       <= 1'b0;
      res.valid <= 1'b0;
      res.data  <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        IDLE: if (full_nxt) state <= LOAD;
        LOAD: begin
          if (step == LAST_STEP) begin
            step  <= '0;
            state <= SORT;
          end else begin
            step <= step + 4'd1;
          end
        end
        SORT: begin
          if (sort_done) begin
            step  <= '0;
            round <= '0;
            cap   <= 1'b1;
            state <= OUT;
          end else if (step == LAST_STEP) begin
            step  <= '0;
            round <= round + 3'd1;
          end else begin
            step <= step + 4'd1;
          end
        end
        OUT: begin
          if (cap) begin
            res.data  <= DO;
            res.valid <= 1'b1;
            cap       <= 1'b0;
          end else if (hs) begin
            res.valid <= 1'b0;
            state     <= full_nxt ? LOAD : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_med_seq.sv
// Directed bench for med_seq with the median engine attached beside it.
module tb_med_seq;

  localparam int SIZE = 8;

  logic            CLK = 1'b0;
  logic            nRST = 1'b0;
  logic            DSI, BYP;
  logic [SIZE-1:0] DI, DO;

  med_seq_if #(.SIZE(SIZE)) pix ();
  med_seq_if #(.SIZE(SIZE)) res ();

  med_seq #(.SIZE(SIZE), .NBR(9)) dut (
    .CLK (CLK), .nRST (nRST), .pix (pix), .res (res),
    .DSI (DSI), .BYP (BYP), .DI (DI), .DO (DO)
  );

  med_eng #(.SIZE(SIZE)) eng (
    .CLK (CLK), .DSI (DSI), .BYP (BYP), .DI (DI), .DO (DO)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] p [9];
    logic [7:0] med;
    int         gap;
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present 9 pixels, optionally with idle gaps before each; LOAD must not
  // start before the 9th transfer.
  task automatic feed(input logic [7:0] p [9], input int gap, input string tag);
    int early = 0;
    int stuck = 0;
    for (int k = 0; k < 9; k++) begin
      for (int g = 0; g < gap; g++) begin
        pix.valid = 1'b0;
        if (DSI !== 1'b0) early++;
        tick();
      end
      pix.valid = 1'b1;
      pix.data  = p[k];
      for (int n = 0; n < 100 && pix.ready !== 1'b1; n++) begin
        if (DSI !== 1'b0) early++;
        tick();
      end
      if (pix.ready !== 1'b1) stuck++;
      if (DSI !== 1'b0) early++;
      tick();
    end
    pix.valid = 1'b0;
    chk({tag, "_early_load"}, early, 0);
    chk({tag, "_accept_timeout"}, stuck, 0);
  endtask

  // Called on the first LOAD cycle; checks the full 54-cycle schedule and
  // the registered result, and returns with RES_VALID expected high.
  task automatic sched(input logic [7:0] p [9], input logic [7:0] med, input string tag);
    int bad_dsi = 0, bad_byp = 0, bad_di = 0, bad_rdy = 0, bad_vld = 0;
    logic       edsi, ebyp;
    logic [7:0] edi;
    for (int c = 0; c < 54; c++) begin
      edsi = (c < 9);
      ebyp = (c < 9) || (c >= 9 && c < 45 && ((c - 9) % 9) == 8);
      edi  = 8'd0;
      if (c < 9) edi = p[c];
      if (DSI !== edsi) bad_dsi++;
      if (BYP !== ebyp) bad_byp++;
      if (DI !== edi) bad_di++;
      if (c < 9 && pix.ready !== 1'b0) bad_rdy++;
      if (res.valid !== 1'b0) bad_vld++;
      tick();
    end
    chk({tag, "_dsi_bad_cycles"}, bad_dsi, 0);
    chk({tag, "_byp_bad_cycles"}, bad_byp, 0);
    chk({tag, "_di_bad_cycles"}, bad_di, 0);
    chk({tag, "_ready_in_load"}, bad_rdy, 0);
    chk({tag, "_valid_early"}, bad_vld, 0);
    chk({tag, "_res_valid_at_54"}, int'(res.valid), 1);
    chk({tag, "_res"}, int'(res.data), int'(med));
  endtask

  task automatic take(input string tag);
    res.ready = 1'b1;
    tick();
    res.ready = 1'b0;
    chk({tag, "_valid_cleared"}, int'(res.valid), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a [9];
    logic [7:0] b [9];
    logic [7:0] c [9];
    logic [7:0] d [9];
    logic [7:0] e [9];
    int hold_bad, stall_bad, load_bad, idle_bad;

    tv[0].p = '{7, 7, 7, 7, 7, 7, 7, 7, 7};                   tv[0].med = 7;   tv[0].gap = 0;
    tv[1].p = '{10, 11, 12, 13, 14, 15, 16, 17, 18};          tv[1].med = 14;  tv[1].gap = 2;
    tv[2].p = '{9, 1, 8, 2, 7, 3, 6, 4, 5};                   tv[2].med = 5;   tv[2].gap = 0;
    tv[3].p = '{255, 0, 255, 0, 255, 0, 255, 0, 128};         tv[3].med = 128; tv[3].gap = 0;
    tv[4].p = '{0, 0, 0, 0, 0, 0, 0, 0, 0};                   tv[4].med = 0;   tv[4].gap = 1;
    tv[5].p = '{200, 200, 200, 200, 200, 1, 1, 1, 1};         tv[5].med = 200; tv[5].gap = 0;
    tv[6].p = '{3, 3, 3, 3, 1, 1, 1, 1, 2};                   tv[6].med = 2;   tv[6].gap = 0;
    tv[7].p = '{50, 40, 30, 20, 10, 60, 70, 80, 90};          tv[7].med = 50;  tv[7].gap = 1;

    a = '{21, 29, 22, 28, 23, 27, 24, 26, 25};
    b = '{90, 10, 80, 20, 70, 30, 60, 40, 50};
    c = '{5, 250, 6, 249, 7, 248, 8, 247, 100};
    d = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
    e = '{33, 44, 11, 99, 66, 22, 88, 55, 77};

    pix.valid = 1'b0;
    pix.data  = '0;
    res.ready = 1'b0;
    nRST      = 1'b0;
    tick();
    tick();
    chk("rst_res_valid", int'(res.valid), 0);
    chk("rst_res", int'(res.data), 0);
    chk("rst_dsi", int'(DSI), 0);
    chk("rst_byp", int'(BYP), 0);
    chk("rst_di", int'(DI), 0);
    chk("rst_pix_ready", int'(pix.ready), 0);
    nRST = 1'b1;
    tick();
    chk("pix_ready_after_rst", int'(pix.ready), 1);

    // Table windows, each from an empty IDLE sequencer.
    for (int i = 0; i < 8; i++) begin
      feed(tv[i].p, tv[i].gap, $sformatf("v%0d", i));
      sched(tv[i].p, tv[i].med, $sformatf("v%0d", i));
      take($sformatf("v%0d", i));
    end

    // Backpressure: result held for 20 cycles while the next window fills.
    feed(a, 0, "bpA");
    sched(a, 8'd25, "bpA");
    hold_bad = 0; stall_bad = 0; load_bad = 0;
    for (int h = 0; h < 20; h++) begin
      if (h < 9) begin
        pix.valid = 1'b1;
        pix.data  = b[h];
        if (pix.ready !== 1'b1) stall_bad++;
      end else begin
        pix.valid = 1'b0;
        if (pix.ready !== 1'b0) stall_bad++;
      end
      if (res.valid !== 1'b1 || res.data !== 8'd25) hold_bad++;
      if (DSI !== 1'b0) load_bad++;
      tick();
    end
    pix.valid = 1'b0;
    chk("bp_res_hold_bad", hold_bad, 0);
    chk("bp_ready_stall_bad", stall_bad, 0);
    chk("bp_load_early", load_bad, 0);
    res.ready = 1'b1;
    tick();
    res.ready = 1'b0;
    sched(b, 8'd50, "bpB");

    // 9th pixel of the next window accepted on the handshake cycle itself.
    for (int h = 0; h < 9; h++) begin
      pix.valid = 1'b1;
      pix.data  = c[h];
      res.ready = (h == 8);
      tick();
    end
    pix.valid = 1'b0;
    res.ready = 1'b0;
    sched(c, 8'd100, "hs9");
    take("hs9");

    // Reset at SORT cycle 20 with 3 pixels of a later window already buffered.
    feed(d, 0, "rstD");
    for (int k = 0; k < 28; k++) begin
      pix.valid = (k >= 9 && k < 12);
      pix.data  = 8'(200 + k);
      tick();
    end
    pix.valid = 1'b0;
    nRST = 1'b0;
    tick();
    chk("midsort_rst_res_valid", int'(res.valid), 0);
    chk("midsort_rst_dsi", int'(DSI), 0);
    chk("midsort_rst_byp", int'(BYP), 0);
    chk("midsort_rst_pix_ready", int'(pix.ready), 0);
    nRST = 1'b1;
    tick();
    chk("midsort_ready_after_rst", int'(pix.ready), 1);
    idle_bad = 0;
    for (int k = 0; k < 60; k++) begin
      if (res.valid !== 1'b0 || DSI !== 1'b0) idle_bad++;
      tick();
    end
    chk("midsort_no_result", idle_bad, 0);
    feed(e, 0, "postrst");
    sched(e, 8'd55, "postrst");
    take("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/med_seq.md
MED_SEQ -- requirements
Module: med_seq

Interface
REQ-001 Parameter SIZE, default 8, pixel width in bits.
REQ-002 Parameter NBR, default 9, pixels per window; only the value 9 is supported.
REQ-003 CLK  input  1  sole clock; all logic on its rising edge.
REQ-004 nRST  input  1  reset, synchronous, active-low.
REQ-005 PIX_IN  input  SIZE  upstream pixel.
REQ-006 PIX_VALID  input  1  PIX_IN is valid.
REQ-007 PIX_READY  output  1  sequencer accepts PIX_IN this cycle.
REQ-008 DSI  output  1  to median engine: load DI into the first stage.
REQ-009 BYP  output  1  to median engine: bypass the compare at the last stage.
REQ-010 DI  output  SIZE  to median engine: pixel data.
REQ-011 DO  input  SIZE  from median engine: last-stage register.
REQ-012 RES  output  SIZE  window median, registered.
REQ-013 RES_VALID  output  1  RES is valid.
REQ-014 RES_READY  input  1  downstream accepts RES.

Function
REQ-015 An input transfer SHALL occur on a cycle with PIX_VALID=1 and PIX_READY=1; the pixel SHALL be written into a 9-entry in-order buffer.
REQ-016 PIX_READY SHALL be 1 when buffer count<9 and state!=LOAD; it SHALL be 0 otherwise.
REQ-017 The FSM SHALL have states IDLE, LOAD, SORT and OUT.
REQ-018 In IDLE, when buffer count reaches 9, the FSM SHALL enter LOAD on the next cycle.
REQ-019 In LOAD, the FSM SHALL stay exactly 9 contiguous cycles.
REQ-020 In LOAD, DSI=1, BYP=1 and DI=the buffer entry in arrival order, one entry per cycle.
REQ-021 On leaving LOAD, the buffer SHALL be empty.
REQ-022 In SORT, the FSM SHALL stay exactly 44 cycles: 4 rounds of (8 cycles BYP=0, then 1 cycle BYP=1), then 8 cycles BYP=0.
REQ-023 In SORT, DSI SHALL be 0 throughout and DI SHALL be 0.
REQ-024 In SORT, a round counter (0..4) and a step counter (0..8) SHALL track the schedule and SHALL wrap to 0 at each round end.
REQ-025 On the cycle after the last SORT cycle, the FSM SHALL capture DO into RES, set RES_VALID=1 and enter OUT.
REQ-026 Latency SHALL be 54 cycles from the first LOAD cycle to RES_VALID=1.
REQ-027 In OUT, RES and RES_VALID SHALL hold until RES_READY=1.
REQ-028 On the OUT handshake cycle, RES_VALID SHALL clear.
REQ-029 On the OUT handshake cycle, the FSM SHALL go to LOAD if buffer count=9 (or a 9th pixel is accepted that cycle); otherwise it SHALL go to IDLE.
REQ-030 Pixel collection for the next window SHALL continue during SORT and OUT.
REQ-031 When the buffer is full, upstream SHALL be stalled (PIX_READY=0).
REQ-032 In IDLE and OUT, DSI=0, BYP=0 and DI=0.
REQ-033 Engine activity in IDLE and OUT is don't-care because RES is already captured.
REQ-034 The buffer count SHALL never exceed 9.
REQ-035 A simultaneous accept and read SHALL not occur, since PIX_READY=0 in LOAD.

Reset
REQ-036 When nRST=0 at a rising edge, the FSM SHALL go to IDLE.
REQ-037 On reset, the buffer SHALL be emptied and all counters cleared.
REQ-038 On reset, outputs SHALL be RES=0, RES_VALID=0, DSI=0, BYP=0, DI=0 and PIX_READY=0.
REQ-039 PIX_READY SHALL assert on the first cycle after nRST returns to 1.
REQ-040 Reset mid-LOAD, mid-SORT or mid-OUT SHALL abort the window and discard buffered pixels.
REQ-041 Reset mid-operation SHALL produce no RES_VALID.

Structure
REQ-042 Package med_pkg SHALL hold the FSM state enum and constants NBR=9, ROUNDS=4, PASS=8 and SORT_CYCLES=44.
REQ-043 The 9-entry pixel buffer (write pointer, read pointer, count) SHALL be a sub-module med_buf.
REQ-044 The FSM and counters SHALL be in med_seq.
REQ-045 The median engine SHALL be instantiated beside med_seq at the next level up, not inside it.

Verification
REQ-046 Reset, then 9 pixels of 7 back-to-back → DSI=1/BYP=1 for 9 cycles; 44-cycle BYP pattern 00000000 1 ×4 then 00000000; RES=7 with RES_VALID=1 at cycle 54; engine instance attached.
REQ-047 Pixels 10..18 with PIX_VALID gaps → LOAD starts only after the 9th accept; DI order is 10..18, contiguous.
REQ-048 RES_READY=0 for 20 cycles while 9 more pixels arrive → RES held stable; PIX_READY=0 after the 9th; LOAD starts the cycle after the handshake.
REQ-049 nRST=0 at SORT cycle 20 → next cycle IDLE, RES_VALID=0, buffer count 0.
REQ-050 Random windows ×1000 → RES equals the engine DO sampled on the cycle after SORT cycle 44.
REQ-051 Random windows ×1000 → schedule cycle counts are exact every window.
